// File: rtl/fpu_issue_sched.sv
// fpu_issue_sched: two-requester round-robin issue scheduler with a single-entry issue register.
// Latency: an op granted at edge k is presented as iss_valid in cycle k+1 unless a long op holds the unit.
// Backpressure: rN_ready drops while the held op is stalled by iss_ready=0, by long-op busy, or by flush.
//
// Ports:
//   clk, reset_n                  clock and synchronous active-low reset
//   rN_valid/rN_ready             requester N handshake (N = 0, 1)
//   rN_op1, rN_op2, rN_op_type,   requester N payload; op_type[3] marks a long op
//   rN_P
//   iss_valid/iss_ready           issue handshake towards the FPU datapath
//   iss_op1, iss_op2, iss_op_type, iss_P, iss_src
//                                 held op and the requester it came from
//   flush                         discard the held op and any long-op busy
//   long_busy, long_done          long op in progress / one-cycle expiry pulse
module fpu_issue_sched #(
  parameter int LONG_LAT = 8,
  parameter int CW       = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          r0_valid,
  output logic          r0_ready,
  input  logic [63:0]   r0_op1,
  input  logic [63:0]   r0_op2,
  input  logic [3:0]    r0_op_type,
  input  logic          r0_P,
  input  logic          r1_valid,
  output logic          r1_ready,
  input  logic [63:0]   r1_op1,
  input  logic [63:0]   r1_op2,
  input  logic [3:0]    r1_op_type,
  input  logic          r1_P,
  output logic          iss_valid,
  input  logic          iss_ready,
  output logic [63:0]   iss_op1,
  output logic [63:0]   iss_op2,
  output logic [3:0]    iss_op_type,
  output logic          iss_P,
  output logic          iss_src,
  input  logic          flush,
  output logic          long_busy,
  output logic          long_done
);

  logic          r_hold_valid;
  logic          r_rr_ptr;
  logic [CW-1:0] r_busy_cnt;
  logic          r_long_done;
  logic [63:0]   r_op1;
  logic [63:0]   r_op2;
  logic [3:0]    r_op_type;
  logic          r_P;
  logic          r_src;

  logic          w_long_busy;
  logic          w_iss_valid;
  logic          w_fire;
  logic          w_can_load;
  logic          w_grant0;
  logic          w_grant1;
  logic          w_load;

  assign w_long_busy = (r_busy_cnt != '0);
  // iss_valid depends only on state, so iss_ready never reaches it combinationally.
  assign w_iss_valid = r_hold_valid & ~w_long_busy;
  assign w_fire      = w_iss_valid & iss_ready;
  // The register frees up either when empty or when its occupant leaves this edge.
  assign w_can_load  = ~flush & (~r_hold_valid | w_fire);

  // A lone requester always wins; on contention rr_ptr picks.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (w_can_load && reset_n) begin
      if (r0_valid && r1_valid) begin
        w_grant0 = ~r_rr_ptr;
        w_grant1 = r_rr_ptr;
      end else begin
        w_grant0 = r0_valid;
        w_grant1 = r1_valid;
      end
    end
  end

  assign w_load = w_grant0 | w_grant1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_hold_valid <= 1'b0;
      r_rr_ptr     <= 1'b0;
      r_busy_cnt   <= '0;
      r_long_done  <= 1'b0;
      r_op1        <= '0;
      r_op2        <= '0;
      r_op_type    <= '0;
      r_P          <= 1'b0;
      r_src        <= 1'b0;
    end else if (flush) begin
      // A fire in this cycle still reaches the datapath, but it does not arm busy.
      r_hold_valid <= 1'b0;
      r_busy_cnt   <= '0;
      r_long_done  <= 1'b0;
    end else begin
      if (w_load) begin
        r_hold_valid <= 1'b1;
        r_src        <= w_grant1;
        r_rr_ptr     <= ~w_grant1;
        r_op1        <= w_grant1 ? r1_op1     : r0_op1;
        r_op2        <= w_grant1 ? r1_op2     : r0_op2;
        r_op_type    <= w_grant1 ? r1_op_type : r0_op_type;
        r_P          <= w_grant1 ? r1_P       : r0_P;
      end else if (w_fire) begin
        r_hold_valid <= 1'b0;
      end

      if (w_fire && r_op_type[3]) begin
        r_busy_cnt <= CW'(LONG_LAT);
      end else if (w_long_busy) begin
        r_busy_cnt <= r_busy_cnt - CW'(1);
      end

      // A fire cannot coincide with count==1 because iss_valid is low while busy.
      r_long_done <= (r_busy_cnt == CW'(1));
    end
  end

  assign r0_ready    = w_grant0;
  assign r1_ready    = w_grant1;
  assign iss_valid   = w_iss_valid;
  assign iss_op1     = r_op1;
  assign iss_op2     = r_op2;
  assign iss_op_type = r_op_type;
  assign iss_P       = r_P;
  assign iss_src     = r_src;
  assign long_busy   = w_long_busy;
  assign long_done   = r_long_done;

endmodule

// File: tb/tb_fpu_issue_sched.sv
// tb_fpu_issue_sched: directed bench for fpu_issue_sched with hand-computed expectations.
// Inputs change 1 time unit after each rising edge; outputs are sampled on the falling edge.
// Covers reset, round-robin, backpressure, long-op busy, flush and flush/grant collision.
module tb_fpu_issue_sched;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        r0_valid, r0_ready, r0_P;
  logic [63:0] r0_op1, r0_op2;
  logic [3:0]  r0_op_type;
  logic        r1_valid, r1_ready, r1_P;
  logic [63:0] r1_op1, r1_op2;
  logic [3:0]  r1_op_type;
  logic        iss_valid, iss_ready, iss_P, iss_src;
  logic [63:0] iss_op1, iss_op2;
  logic [3:0]  iss_op_type;
  logic        flush, long_busy, long_done;

  int n_run  = 0;
  int n_fail = 0;

  localparam logic [63:0] OP_A = 64'h3FF0000000000000;
  localparam logic [63:0] OP_B = 64'h4000000000000000;

  always #5 clk = ~clk;

  fpu_issue_sched #(.LONG_LAT(8), .CW(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op1(r0_op1), .r0_op2(r0_op2),
    .r0_op_type(r0_op_type), .r0_P(r0_P),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op1(r1_op1), .r1_op2(r1_op2),
    .r1_op_type(r1_op_type), .r1_P(r1_P),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op1(iss_op1), .iss_op2(iss_op2),
    .iss_op_type(iss_op_type), .iss_P(iss_P), .iss_src(iss_src),
    .flush(flush), .long_busy(long_busy), .long_done(long_done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  logic [63:0] exp_op;
  logic        exp_src;
  int          n0, n1;
  logic        g;

  initial begin
    reset_n = 1'b0; flush = 1'b0; iss_ready = 1'b0;
    r0_valid = 1'b1; r0_op1 = OP_A; r0_op2 = 64'hC0DE; r0_op_type = 4'h2; r0_P = 1'b1;
    r1_valid = 1'b0; r1_op1 = '0; r1_op2 = 64'hBEEF; r1_op_type = 4'h0; r1_P = 1'b0;

    // Reset held for 3 edges with r0_valid high
    for (int i = 0; i < 3; i++) begin
      cyc();
      settle();
      chk("rst_r0_ready", 64'(r0_ready), 64'd0);
      chk("rst_iss_valid", 64'(iss_valid), 64'd0);
    end
    chk("rst_op1", iss_op1, 64'd0);
    chk("rst_op2", iss_op2, 64'd0);
    chk("rst_type", 64'(iss_op_type), 64'd0);
    chk("rst_P", 64'(iss_P), 64'd0);
    chk("rst_src", 64'(iss_src), 64'd0);
    chk("rst_busy", 64'(long_busy), 64'd0);
    chk("rst_done", 64'(long_done), 64'd0);

    cyc();
    reset_n = 1'b1;
    settle();
    chk("rel_r0_ready", 64'(r0_ready), 64'd1);
    chk("rel_iss_valid", 64'(iss_valid), 64'd0);
    cyc();

    // Backpressure: held op A for 4 cycles, both requesters asking
    r1_valid = 1'b1; r1_op1 = OP_B;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("bp_iss_valid", 64'(iss_valid), 64'd1);
      chk("bp_op1", iss_op1, OP_A);
      chk("bp_op2", iss_op2, 64'hC0DE);
      chk("bp_type", 64'(iss_op_type), 64'h2);
      chk("bp_src", 64'(iss_src), 64'd0);
      chk("bp_r0_ready", 64'(r0_ready), 64'd0);
      chk("bp_r1_ready", 64'(r1_ready), 64'd0);
      cyc();
    end
    // Release: A fires and B loads in the same edge
    iss_ready = 1'b1; r0_valid = 1'b0;
    settle();
    chk("bp_rel_r1_ready", 64'(r1_ready), 64'd1);
    chk("bp_rel_r0_ready", 64'(r0_ready), 64'd0);
    cyc();

    // Round-robin, pointer at 0 after the r1 grant; B still held and firing
    exp_src = 1'b1; exp_op = OP_B; n0 = 0; n1 = 0;
    for (int i = 0; i < 6; i++) begin
      g = (i % 2 == 1);
      r0_valid = 1'b1; r1_valid = 1'b1;
      r0_op1 = 64'hA0 + 64'(n0); r1_op1 = 64'hB0 + 64'(n1);
      settle();
      chk("rr_iss_valid", 64'(iss_valid), 64'd1);
      chk("rr_src", 64'(iss_src), 64'(exp_src));
      chk("rr_op1", iss_op1, exp_op);
      chk("rr_r0_ready", 64'(r0_ready), 64'(!g));
      chk("rr_r1_ready", 64'(r1_ready), 64'(g));
      cyc();
      exp_src = g;
      exp_op  = g ? (64'hB0 + 64'(n1)) : (64'hA0 + 64'(n0));
      if (g) n1++; else n0++;
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    settle();
    chk("rr_last_src", 64'(iss_src), 64'd1);
    chk("rr_last_op1", iss_op1, 64'hB2);
    cyc();

    // Long op then short op; pointer now 0
    r0_valid = 1'b1; r0_op_type = 4'b1000; r0_op1 = 64'hD1;
    settle();
    chk("lo_load_ready", 64'(r0_ready), 64'd1);
    cyc();
    r0_op_type = 4'b0000; r0_op1 = 64'h55;
    settle();
    chk("lo_fire_valid", 64'(iss_valid), 64'd1);
    chk("lo_fire_type", 64'(iss_op_type), 64'h8);
    chk("lo_short_ready", 64'(r0_ready), 64'd1);
    cyc();
    r0_valid = 1'b0; r1_valid = 1'b1; r1_op1 = 64'h77; r1_op_type = 4'h0;
    for (int k = 1; k <= 8; k++) begin
      settle();
      chk("lo_busy", 64'(long_busy), 64'd1);
      chk("lo_iss_valid", 64'(iss_valid), 64'd0);
      chk("lo_done_early", 64'(long_done), 64'd0);
      chk("lo_r1_ready", 64'(r1_ready), 64'd0);
      cyc();
    end
    r1_valid = 1'b0;
    settle();
    chk("lo_busy_end", 64'(long_busy), 64'd0);
    chk("lo_done", 64'(long_done), 64'd1);
    chk("lo_next_valid", 64'(iss_valid), 64'd1);
    chk("lo_next_op1", iss_op1, 64'h55);
    chk("lo_next_type", 64'(iss_op_type), 64'h0);
    cyc();
    settle();
    chk("lo_done_pulse", 64'(long_done), 64'd0);
    chk("lo_drained", 64'(iss_valid), 64'd0);
    cyc();

    // Flush during long op; pointer now 1
    r1_valid = 1'b1; r1_op_type = 4'b1001; r1_op1 = 64'hE1;
    settle();
    chk("fl_load_r1", 64'(r1_ready), 64'd1);
    cyc();
    r1_valid = 1'b0; r0_valid = 1'b1; r0_op_type = 4'h0; r0_op1 = 64'h66;
    settle();
    chk("fl_fire_type", 64'(iss_op_type), 64'h9);
    chk("fl_short_ready", 64'(r0_ready), 64'd1);
    cyc();
    r0_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("fl_busy", 64'(long_busy), 64'd1);
      cyc();
    end
    flush = 1'b1;
    settle();
    chk("fl_busy_at_flush", 64'(long_busy), 64'd1);
    cyc();
    flush = 1'b0;
    r0_valid = 1'b1; r1_valid = 1'b1; r0_op1 = 64'h81; r1_op1 = 64'h91; r1_op_type = 4'h0;
    settle();
    chk("fl_busy_clr", 64'(long_busy), 64'd0);
    chk("fl_hold_clr", 64'(iss_valid), 64'd0);
    chk("fl_done_none", 64'(long_done), 64'd0);
    chk("fl_rr_r1", 64'(r1_ready), 64'd1);
    chk("fl_rr_r0", 64'(r0_ready), 64'd0);
    cyc();
    r0_valid = 1'b0; r1_valid = 1'b0;
    settle();
    chk("fl_after_src", 64'(iss_src), 64'd1);
    chk("fl_after_op1", iss_op1, 64'h91);
    cyc();
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("fl_no_done", 64'(long_done), 64'd0);
      cyc();
    end

    // Flush vs grant collision with an empty register
    flush = 1'b1; r0_valid = 1'b1; r0_op1 = 64'h33;
    settle();
    chk("col_flush_ready", 64'(r0_ready), 64'd0);
    cyc();
    flush = 1'b0;
    settle();
    chk("col_after_ready", 64'(r0_ready), 64'd1);
    cyc();
    r0_valid = 1'b0;
    settle();
    chk("col_iss_valid", 64'(iss_valid), 64'd1);
    chk("col_iss_src", 64'(iss_src), 64'd0);
    chk("col_iss_op1", iss_op1, 64'h33);
    cyc();

    // Reset in the middle of a long op
    r0_valid = 1'b1; r0_op_type = 4'b1000; r0_op1 = 64'h44;
    cyc();
    r0_valid = 1'b0;
    settle();
    chk("mr_fire_valid", 64'(iss_valid), 64'd1);
    cyc();
    settle();
    chk("mr_busy", 64'(long_busy), 64'd1);
    cyc();
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    settle();
    chk("mr_busy_clr", 64'(long_busy), 64'd0);
    for (int k = 0; k < 10; k++) begin
      settle();
      chk("mr_no_done", 64'(long_done), 64'd0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_issue_sched.md
# fpu_issue_sched

Two-requester issue scheduler for the FPU front end. It arbitrates round-robin between two operand sources and holds the winning operation in a single-entry issue register. It presents that operation (op1, op2, op_type, P) to the FPU input-conversion/datapath stage over a valid/ready handshake. It also blocks further issue while a long-latency (divide/sqrt-class) operation occupies the unit.

## Interface
Parameters:
- `LONG_LAT`, default 8: cycles the unit stays busy after a long op is accepted. Legal range 1..255.
- `CW`, default 8: width of the busy counter. Must satisfy 2^CW > LONG_LAT.

Ports:
- `clk` input 1: single clock. All state updates on the rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `r0_valid` input 1: requester 0 has an op. Must not depend on `r0_ready`.
- `r0_ready` output 1: requester 0 op accepted this cycle.
- `r0_op1`, `r0_op2` input 64 each: requester 0 operands.
- `r0_op_type` input 4: requester 0 opcode. Bit 3 = long op.
- `r0_P` input 1: requester 0 precision. 0 = double, 1 = single.
- `r1_valid`, `r1_ready`, `r1_op1`, `r1_op2`, `r1_op_type`, `r1_P`: same as the r0 ports, for requester 1.
- `iss_valid` output 1: issue register holds an op and the unit is free.
- `iss_ready` input 1: datapath accepts the op.
- `iss_op1`, `iss_op2` output 64 each: issued operands.
- `iss_op_type` output 4: issued opcode.
- `iss_P` output 1: issued precision.
- `iss_src` output 1: requester index of the issued op.
- `flush` input 1: synchronous discard of the held op and of long-op busy.
- `long_busy` output 1: long op in progress.
- `long_done` output 1: one-cycle pulse when long-op busy expires.

## Operation
- Internal state:
  - `hold_valid`: the issue register is occupied.
  - `rr_ptr`: which requester has priority.
  - `busy_cnt`: CW bits.
- `iss_valid = hold_valid & ~long_busy`.
- `long_busy = (busy_cnt != 0)`.
- Issue handshake: `fire = iss_valid & iss_ready`.
- Load condition: `can_load = ~flush & (~hold_valid | fire)`.
- Arbitration, evaluated when `can_load` is 1:
  - One requester valid: that requester is granted.
  - Both valid: the requester equal to `rr_ptr` is granted.
  - `rN_ready = can_load & grant_N`. At most one ready per cycle.
- On a grant to N:
  - The issue register loads `rN_*` and sets `iss_src = N`.
  - `hold_valid` becomes 1.
  - `rr_ptr` becomes `~N`.
  - With no grant, `rr_ptr` is unchanged.
- On `fire` with no new grant, `hold_valid` becomes 0.
- Operands, op_type and P pass unmodified. Precision and sign handling belong to the conversion stage.
- Long-op busy counter:
  - On `fire` with `iss_op_type[3] = 1`, `busy_cnt` loads `LONG_LAT`.
  - Otherwise, when nonzero, it decrements by 1.
  - `long_done` is 1 in the cycle `busy_cnt` transitions 1 -> 0, registered.
- While `long_busy` is high:
  - `iss_valid` is 0.
  - The held op, including a following short op, waits.
  - No new load can occur if `hold_valid` is set, so requesters see `ready = 0`.
- `flush` takes priority over everything:
  - Next cycle: `hold_valid = 0`, `busy_cnt = 0`, `long_done = 0`.
  - No grant occurs in the flush cycle.
  - `rr_ptr` is retained.
  - A `fire` in the flush cycle is still seen by the datapath. The scheduler does not start `busy_cnt` for it.
- Simultaneous `fire` and grant: the register is replaced by the new op in the same edge, with no bubble.

## Timing
- Reset (reset_n = 0 at an edge) sets:
  - `hold_valid = 0`, hence `iss_valid = 0`.
  - `iss_op1 = 0`, `iss_op2 = 0`, `iss_op_type = 0`, `iss_P = 0`, `iss_src = 0`.
  - `rr_ptr = 0`, `busy_cnt = 0`.
  - `long_busy = 0`, `long_done = 0`.
  - `r0_ready` and `r1_ready` are 0 during reset.
- Reset asserted mid long op clears busy immediately. No `long_done` pulse is produced.
- Latency: an op accepted at edge k (`rN_valid & rN_ready`) shows `iss_valid = 1` in cycle k+1, provided the unit is not busy.
- Throughput: 1 op/cycle with `iss_ready` held high and only short ops.
- Long op accepted at edge k:
  - `long_busy` is high in cycles k+1 .. k+LONG_LAT.
  - `long_done` is high in cycle k+LONG_LAT+1.
  - The next op can issue (`iss_valid`) in cycle k+LONG_LAT+1.
- `r*_ready` is combinational from `r*_valid`, `hold_valid`, `fire`, `flush`, `rr_ptr` and `busy_cnt`. There is no combinational path from `iss_ready` to `iss_valid`.

## Test plan
- **Reset:** hold `reset_n = 0` for 3 cycles with `r0_valid = 1`. Required: `r0_ready = 0`, `iss_valid = 0` and all `iss_*` = 0. Release reset. Required: `r0_ready = 1` in the next cycle, and `iss_valid = 1` with `iss_src = 0` one cycle later.
- **Round-robin:** hold `r0_valid` and `r1_valid` at 1 and `iss_ready` at 1 for 6 cycles. Required: `iss_src` sequence 0,1,0,1,0,1. Every requester payload appears exactly once, in order.
- **Backpressure:** `iss_ready = 0` for 4 cycles with an op held (op1 = 0x3FF0000000000000). Required: `iss_*` stable, both readies 0. Then `iss_ready = 1` with `r1_valid = 1`. Required: fire and new load in the same edge, no bubble.
- **Long op:** `LONG_LAT = 8`. Issue op_type 4'b1000 at cycle 10, then a short op 4'b0000. Required: `long_busy` high for cycles 11–18, `long_done` high at cycle 19, second op `iss_valid` at cycle 19.
- **Flush during long op:** flush at cycle 13 of the long-op case above. Required: `long_busy = 0` and `hold_valid = 0` at cycle 14, no `long_done` pulse, `rr_ptr` unchanged.
- **Flush vs. grant collision:** `flush = 1` while `r0_valid = 1` and the issue register is empty. Required: `r0_ready = 0` in the flush cycle. `r0_ready = 1` in the following cycle.
